// File: rtl/jk_cmd_sequencer.sv
// Command FIFO plus replay FSM that drives the jk input of a downstream JK flop.
// Each queued op is held on jk for len+1 cycles; commands run back-to-back with no gap.
module jk_cmd_sequencer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [CW-1:0]            cmd_len,
   output logic [1:0]               jk,
   output logic                     busy,
   output logic                     cmd_done,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned EW = 2 + CW;

   typedef enum logic {IDLE, RUN} state_t;

   logic [EW-1:0]  mem [DEPTH];
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [CW-1:0]  cnt;
   state_t         state;
   logic           push;
   logic           pop;
   logic [1:0]     head_op;
   logic [CW-1:0]  head_len;

   assign cmd_ready = !rst && (level != LW'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   // Head is taken when idle, or when the running command finishes its last cycle.
   assign pop       = (level != '0) && ((state == IDLE) || (cnt == '0));
   assign {head_op, head_len} = mem[rptr];

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= {cmd_op, cmd_len};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         cnt      <= '0;
         jk       <= 2'b00;
         busy     <= 1'b0;
         cmd_done <= 1'b0;
         state    <= IDLE;
      end else begin
         cmd_done <= 1'b0;
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         if (push && !pop)      level <= level + LW'(1);
         else if (!push && pop) level <= level - LW'(1);

         case (state)
            IDLE: begin
               if (pop) begin
                  jk    <= head_op;
                  cnt   <= head_len;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  cmd_done <= 1'b1;
                  if (pop) begin
                     jk  <= head_op;
                     cnt <= head_len;
                  end else begin
                     jk    <= 2'b00;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: a schedule-based reference model predicts
// each command's start/end edge from its accept edge, and every output is compared per cycle.
module tb_jk_cmd_sequencer;

   localparam int DEPTH = 4;
   localparam int CW    = 8;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CW-1:0]    cmd_len;
   logic [1:0]       jk;
   logic             busy;
   logic             cmd_done;
   logic [2:0]       level;

   jk_cmd_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .jk(jk), .busy(busy),
      .cmd_done(cmd_done), .level(level)
   );

   always #5 clk = ~clk;

   // Reference schedule: accepted at edge a, drives op after edges s..e-1, done pulses after edge e.
   typedef struct { int op; int len; int a; int s; int e; } cmd_t;
   cmd_t q[$];
   int   t;
   int   checks;
   int   failures;
   bit   rdy_obs;
   bit   rdy_exp;
   bit   acc_last;

   function automatic int exp_jk(int tt);
      foreach (q[i]) if (q[i].s <= tt && tt < q[i].e) return q[i].op;
      return 0;
   endfunction

   function automatic int exp_busy(int tt);
      foreach (q[i]) if (q[i].s <= tt && tt < q[i].e) return 1;
      return 0;
   endfunction

   function automatic int exp_done(int tt);
      foreach (q[i]) if (q[i].e == tt) return 1;
      return 0;
   endfunction

   function automatic int exp_level(int tt);
      int n = 0;
      foreach (q[i]) if (q[i].a <= tt && q[i].s > tt) n++;
      return n;
   endfunction

   // Drive one cycle of stimulus, advance one edge, update the schedule with any accept.
   task automatic tick(input bit v, input int op, input int len);
      int   lvl;
      bit   acc;
      cmd_t c;
      cmd_valid = v;
      cmd_op    = 2'(op);
      cmd_len   = CW'(len);
      lvl = exp_level(t);
      acc = v && (lvl < DEPTH);
      #1;
      rdy_obs  = cmd_ready;
      rdy_exp  = (lvl < DEPTH);
      acc_last = acc;
      @(posedge clk);
      t++;
      if (acc) begin
         c.op = op; c.len = len; c.a = t; c.s = t + 1;
         if (q.size() > 0 && q[$].e > c.s) c.s = q[$].e;
         c.e = c.s + len + 1;
         q.push_back(c);
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1; cmd_valid = 1; cmd_op = 2'b11; cmd_len = 8'd1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready t=%0d got=%0b exp=0", t, cmd_ready); end
         @(posedge clk); t++; #1;
         checks++; if (jk !== 2'b00) begin failures++; $display("FAIL reset_jk t=%0d got=%0b exp=00", t, jk); end
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy t=%0d got=%0b exp=0", t, busy); end
         checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level t=%0d got=%0d exp=0", t, level); end
         checks++; if (cmd_done !== 1'b0) begin failures++; $display("FAIL reset_done t=%0d got=%0b exp=0", t, cmd_done); end
      end
      q.delete();
      rst = 0; cmd_valid = 0;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL release_ready t=%0d got=%0b exp=1", t, cmd_ready); end
   endtask

   task automatic test_single();
      int nbusy = 0, ndone = 0;
      for (int i = 0; i < 7; i++) begin
         if (i == 0) tick(1, 1, 2); else tick(0, 0, 0);
         checks++; if (rdy_obs !== rdy_exp) begin failures++; $display("FAIL single_ready t=%0d got=%0b exp=%0b", t, rdy_obs, rdy_exp); end
         checks++; if (jk !== 2'(exp_jk(t))) begin failures++; $display("FAIL single_jk t=%0d got=%0b exp=%0b", t, jk, 2'(exp_jk(t))); end
         checks++; if (busy !== 1'(exp_busy(t))) begin failures++; $display("FAIL single_busy t=%0d got=%0b exp=%0b", t, busy, exp_busy(t)); end
         checks++; if (cmd_done !== 1'(exp_done(t))) begin failures++; $display("FAIL single_done t=%0d got=%0b exp=%0b", t, cmd_done, exp_done(t)); end
         checks++; if (level !== 3'(exp_level(t))) begin failures++; $display("FAIL single_level t=%0d got=%0d exp=%0d", t, level, exp_level(t)); end
         if (busy === 1'b1) nbusy++;
         if (cmd_done === 1'b1) ndone++;
      end
      checks++; if (nbusy != 3) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=3", nbusy); end
      checks++; if (ndone != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", ndone); end
   endtask

   task automatic test_back_to_back();
      int ops[4]  = '{2, 3, 0, 1};
      int lens[4] = '{0, 1, 0, 3};
      int seq[8]  = '{2, 3, 3, 0, 1, 1, 1, 1};
      int ndone = 0;
      for (int i = 0; i < 13; i++) begin
         if (i < 4) tick(1, ops[i], lens[i]); else tick(0, 0, 0);
         checks++; if (jk !== 2'(exp_jk(t))) begin failures++; $display("FAIL b2b_jk t=%0d got=%0b exp=%0b", t, jk, 2'(exp_jk(t))); end
         checks++; if (busy !== 1'(exp_busy(t))) begin failures++; $display("FAIL b2b_busy t=%0d got=%0b exp=%0b", t, busy, exp_busy(t)); end
         checks++; if (cmd_done !== 1'(exp_done(t))) begin failures++; $display("FAIL b2b_done t=%0d got=%0b exp=%0b", t, cmd_done, exp_done(t)); end
         checks++; if (level !== 3'(exp_level(t))) begin failures++; $display("FAIL b2b_level t=%0d got=%0d exp=%0d", t, level, exp_level(t)); end
         if (i >= 1 && i <= 8) begin
            checks++; if (jk !== 2'(seq[i-1])) begin failures++; $display("FAIL b2b_seq i=%0d got=%0b exp=%0b", i, jk, 2'(seq[i-1])); end
         end
         if (i == 9) begin
            checks++; if (jk !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%0b exp=00", jk); end
         end
         if (cmd_done === 1'b1) ndone++;
      end
      checks++; if (ndone != 4) begin failures++; $display("FAIL b2b_done_count got=%0d exp=4", ndone); end
   endtask

   task automatic test_full();
      int ops[6]; int lens[6];
      int idx = 0, maxlvl = 0, t0 = 0, f_edge = -1;
      bit saw_notready = 0, saw_full = 0;
      ops[0] = 3; lens[0] = 20;
      for (int i = 1; i < 6; i++) begin ops[i] = $urandom_range(0, 3); lens[i] = $urandom_range(0, 2); end
      for (int i = 0; i < 80; i++) begin
         tick(idx < 6, ops[idx < 6 ? idx : 0], lens[idx < 6 ? idx : 0]);
         if (i == 0) t0 = t;
         if (acc_last) begin if (idx == 5) f_edge = t; idx++; end
         if (!rdy_obs) saw_notready = 1;
         if (int'(level) > maxlvl) maxlvl = int'(level);
         if (level === 3'd4) saw_full = 1;
         checks++; if (rdy_obs !== rdy_exp) begin failures++; $display("FAIL full_ready t=%0d got=%0b exp=%0b", t, rdy_obs, rdy_exp); end
         checks++; if (jk !== 2'(exp_jk(t))) begin failures++; $display("FAIL full_jk t=%0d got=%0b exp=%0b", t, jk, 2'(exp_jk(t))); end
         checks++; if (cmd_done !== 1'(exp_done(t))) begin failures++; $display("FAIL full_done t=%0d got=%0b exp=%0b", t, cmd_done, exp_done(t)); end
         checks++; if (level !== 3'(exp_level(t))) begin failures++; $display("FAIL full_level t=%0d got=%0d exp=%0d", t, level, exp_level(t)); end
      end
      cmd_valid = 0;
      checks++; if (!saw_full || maxlvl != 4) begin failures++; $display("FAIL full_max_level got=%0d exp=4", maxlvl); end
      checks++; if (!saw_notready) begin failures++; $display("FAIL full_ready_drop got=%0b exp=1", saw_notready); end
      checks++; if (f_edge - t0 != 23) begin failures++; $display("FAIL full_sixth_accept got=%0d exp=23", f_edge - t0); end
   endtask

   task automatic test_reset_mid();
      tick(1, 2, 10); tick(1, 3, 1); tick(1, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
      checks++; if (jk !== 2'b10) begin failures++; $display("FAIL mid_pre_jk got=%0b exp=10", jk); end
      checks++; if (level !== 3'd2) begin failures++; $display("FAIL mid_pre_level got=%0d exp=2", level); end
      rst = 1; cmd_valid = 0;
      #1;
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%0b exp=0", cmd_ready); end
      @(posedge clk); t++; #1;
      q.delete();
      rst = 0;
      checks++; if (jk !== 2'b00) begin failures++; $display("FAIL mid_jk got=%0b exp=00", jk); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", busy); end
      checks++; if (level !== 3'd0) begin failures++; $display("FAIL mid_level got=%0d exp=0", level); end
      checks++; if (cmd_done !== 1'b0) begin failures++; $display("FAIL mid_done got=%0b exp=0", cmd_done); end
      tick(0, 0, 0);
      checks++; if (cmd_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_after got=%0b%0b exp=00", cmd_done, busy); end
      test_single();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if (i < 360) tick($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 4));
         else tick(0, 0, 0);
         checks++; if (rdy_obs !== rdy_exp) begin failures++; $display("FAIL rand_ready t=%0d got=%0b exp=%0b", t, rdy_obs, rdy_exp); end
         checks++; if (jk !== 2'(exp_jk(t))) begin failures++; $display("FAIL rand_jk t=%0d got=%0b exp=%0b", t, jk, 2'(exp_jk(t))); end
         checks++; if (busy !== 1'(exp_busy(t))) begin failures++; $display("FAIL rand_busy t=%0d got=%0b exp=%0b", t, busy, exp_busy(t)); end
         checks++; if (cmd_done !== 1'(exp_done(t))) begin failures++; $display("FAIL rand_done t=%0d got=%0b exp=%0b", t, cmd_done, exp_done(t)); end
         checks++; if (level !== 3'(exp_level(t))) begin failures++; $display("FAIL rand_level t=%0d got=%0d exp=%0d", t, level, exp_level(t)); end
      end
   endtask

   task automatic test_max_len();
      int run = 0, t0 = 0, done_at = -1;
      tick(1, 3, 255);
      t0 = t;
      for (int i = 0; i < 300 && done_at < 0; i++) begin
         tick(0, 0, 0);
         if (jk === 2'b11) run++;
         if (cmd_done === 1'b1) begin
            done_at = t;
            checks++; if (jk !== 2'b00) begin failures++; $display("FAIL max_end_jk got=%0b exp=00", jk); end
         end
         checks++; if (jk !== 2'(exp_jk(t))) begin failures++; $display("FAIL max_jk t=%0d got=%0b exp=%0b", t, jk, 2'(exp_jk(t))); end
      end
      checks++; if (done_at < 0) begin failures++; $display("FAIL max_timeout got=none exp=done"); end
      checks++; if (run != 256) begin failures++; $display("FAIL max_run got=%0d exp=256", run); end
      checks++; if (done_at - t0 != 257) begin failures++; $display("FAIL max_done_edge got=%0d exp=257", done_at - t0); end
   endtask

   initial begin
      clk = 0; rst = 1; cmd_valid = 0; cmd_op = 2'b00; cmd_len = '0;
      t = 0; checks = 0; failures = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_reset_mid();
      test_random();
      test_max_len();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
